// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the writeback stage.
// Writeback source encodings, load funct3 codes, FSM state constants.
package pipe_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_CSR = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef logic [0:0] wb_state_e;
  localparam wb_state_e IDLE     = 1'b0;
  localparam wb_state_e WAIT_MEM = 1'b1;

  // Halfword loads need an even address; word loads need a word-aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    is_misaligned = ((funct3 == F3_LH || funct3 == F3_LHU) && offset[0]) ||
                    ((funct3 == F3_LW) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Execute-to-writeback handshake: instruction fields downstream, stall upstream.
interface writeback_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              ex_valid;
  logic              ex_reg_wr;
  logic [REG_AW-1:0] ex_rd;
  logic [1:0]        ex_wb_sel;
  logic [XLEN-1:0]   ex_alu_result;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_csr_rdata;
  logic [2:0]        ex_funct3;
  logic              stall;

  modport master (
    output ex_valid, ex_reg_wr, ex_rd, ex_wb_sel, ex_alu_result, ex_pc, ex_csr_rdata, ex_funct3,
    input  stall
  );

  modport slave (
    input  ex_valid, ex_reg_wr, ex_rd, ex_wb_sel, ex_alu_result, ex_pc, ex_csr_rdata, ex_funct3,
    output stall
  );
endinterface

// File: rtl/writeback_stage_load_align.sv
// Combinational load aligner: picks byte/half/word from the raw memory word
// by address offset and sign- or zero-extends it per funct3.
module load_align
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = word[gi*8 +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = word[gi*16 +: 16];
    end
  endgenerate

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = byte_lane[offset];
  assign sel_half = half_lane[offset[1]];

  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, sel_byte};
      F3_LH:   data = {{(XLEN-16){sel_half[15]}}, sel_half};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, sel_half};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects the result source, waits on load responses with
// stall, and drives a registered register-file write port plus bypass copy.
// Optional WB_MISALIGN_EN adds misalign_err and suppresses misaligned load writes.
module writeback_stage
  import pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  writeback_stage_if.slave  ex,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              reg_wr,
  output logic [REG_AW-1:0] waddr,
  output logic [XLEN-1:0]   wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
`ifdef WB_MISALIGN_EN
  ,
  output logic              misalign_err
`endif
);

  wb_state_e         state_reg, state_next;
  logic [REG_AW-1:0] rd_reg, rd_next;
  logic              wr_pend_reg, wr_pend_next;
  logic [2:0]        f3_reg, f3_next;
  logic [1:0]        off_reg, off_next;

  logic              reg_wr_reg, reg_wr_next;
  logic [REG_AW-1:0] waddr_reg, waddr_next;
  logic [XLEN-1:0]   wdata_reg, wdata_next;
  logic              mis_reg, mis_next;

  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   src_data;
  logic              ex_writes;
  logic              resp_mis;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3 (f3_reg),
    .offset (off_reg),
    .word   (dmem_rdata),
    .data   (load_data)
  );

  assign ex_writes = ex.ex_reg_wr && (ex.ex_rd != '0);

  always_comb begin
    src_data = ex.ex_alu_result;
    case (wb_sel_e'(ex.ex_wb_sel))
      WB_PC4:  src_data = ex.ex_pc + XLEN'(4);
      WB_CSR:  src_data = ex.ex_csr_rdata;
      default: src_data = ex.ex_alu_result;
    endcase
  end

`ifdef WB_MISALIGN_EN
  assign resp_mis = is_misaligned(f3_reg, off_reg);
`else
  assign resp_mis = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    rd_next      = rd_reg;
    wr_pend_next = wr_pend_reg;
    f3_next      = f3_reg;
    off_next     = off_reg;
    reg_wr_next  = 1'b0;
    waddr_next   = waddr_reg;
    wdata_next   = wdata_reg;
    mis_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ex.ex_valid) begin
          if (wb_sel_e'(ex.ex_wb_sel) == WB_MEM) begin
            rd_next      = ex.ex_rd;
            wr_pend_next = ex_writes;
            f3_next      = ex.ex_funct3;
            off_next     = ex.ex_alu_result[1:0];
            state_next   = WAIT_MEM;
          end else begin
            reg_wr_next = ex_writes;
            waddr_next  = ex.ex_rd;
            wdata_next  = src_data;
          end
        end
      end
      default: begin
        // The response is consumed even when the write is suppressed.
        if (dmem_rvalid) begin
          reg_wr_next = wr_pend_reg && !resp_mis;
          mis_next    = resp_mis;
          waddr_next  = rd_reg;
          wdata_next  = load_data;
          state_next  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      rd_reg      <= '0;
      wr_pend_reg <= 1'b0;
      f3_reg      <= '0;
      off_reg     <= '0;
      reg_wr_reg  <= 1'b0;
      waddr_reg   <= '0;
      wdata_reg   <= '0;
      mis_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_reg      <= rd_next;
      wr_pend_reg <= wr_pend_next;
      f3_reg      <= f3_next;
      off_reg     <= off_next;
      reg_wr_reg  <= reg_wr_next;
      waddr_reg   <= waddr_next;
      wdata_reg   <= wdata_next;
      mis_reg     <= mis_next;
    end
  end

  // Decoded from registered state only, so no path from dmem_rvalid to stall.
  assign ex.stall  = (state_reg == WAIT_MEM);

  assign reg_wr    = reg_wr_reg;
  assign waddr     = waddr_reg;
  assign wdata     = wdata_reg;
  assign fwd_valid = reg_wr_reg;
  assign fwd_rd    = waddr_reg;
  assign fwd_data  = wdata_reg;

`ifdef WB_MISALIGN_EN
  assign misalign_err = mis_reg;
`else
  logic unused_mis;
  assign unused_mis = mis_reg;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage; honours WB_MISALIGN_EN when defined.
module tb_writeback_stage;
  import pipe_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              dmem_rvalid;
  logic [XLEN-1:0]   dmem_rdata;
  logic              reg_wr;
  logic [REG_AW-1:0] waddr;
  logic [XLEN-1:0]   wdata;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [XLEN-1:0]   fwd_data;
`ifdef WB_MISALIGN_EN
  logic              misalign_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  writeback_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) exif ();

  writeback_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex          (exif.slave),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .reg_wr      (reg_wr),
    .waddr       (waddr),
    .wdata       (wdata),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data)
`ifdef WB_MISALIGN_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] csr, input logic [2:0] f3);
    exif.ex_valid      = 1'b1;
    exif.ex_wb_sel     = sel;
    exif.ex_rd         = rd;
    exif.ex_reg_wr     = wr;
    exif.ex_alu_result = alu;
    exif.ex_pc         = pc;
    exif.ex_csr_rdata  = csr;
    exif.ex_funct3     = f3;
  endtask

  // Issue a load, respond after 'lat' stall cycles, then check the write cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [4:0] rd, input int lat,
                         input logic exp_wr, input logic [31:0] exp_data, input logic exp_mis);
    issue(2'b01, rd, 1'b1, addr, 32'h0, 32'h0, f3);
    step();
    exif.ex_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      check({tag, " stall"}, {31'b0, exif.stall}, 32'd1);
      check({tag, " no_wr_wait"}, {31'b0, reg_wr}, 32'd0);
      if (i == lat - 1) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
      end
      step();
    end
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    check({tag, " stall_off"}, {31'b0, exif.stall}, 32'd0);
    check({tag, " reg_wr"}, {31'b0, reg_wr}, {31'b0, exp_wr});
    if (exp_wr) begin
      check({tag, " waddr"}, {27'b0, waddr}, {27'b0, rd});
      check({tag, " wdata"}, wdata, exp_data);
      check({tag, " fwd_data"}, fwd_data, exp_data);
    end
`ifdef WB_MISALIGN_EN
    check({tag, " misalign"}, {31'b0, misalign_err}, {31'b0, exp_mis});
`else
    if (exp_mis) check({tag, " mis_unexpected"}, 32'd0, 32'd1);
`endif
  endtask

  initial begin
    rst = 1'b1;
    dmem_rvalid = 1'b0;
    dmem_rdata = 32'h0;
    exif.ex_valid = 1'b0;
    exif.ex_wb_sel = 2'b00;
    exif.ex_rd = '0;
    exif.ex_reg_wr = 1'b0;
    exif.ex_alu_result = '0;
    exif.ex_pc = '0;
    exif.ex_csr_rdata = '0;
    exif.ex_funct3 = '0;
    step();
    step();
    check("rst reg_wr", {31'b0, reg_wr}, 32'd0);
    check("rst waddr", {27'b0, waddr}, 32'd0);
    check("rst wdata", wdata, 32'd0);
    check("rst stall", {31'b0, exif.stall}, 32'd0);
`ifdef WB_MISALIGN_EN
    check("rst misalign", {31'b0, misalign_err}, 32'd0);
`endif
    rst = 1'b0;
    step();
    check("idle no_wr", {31'b0, reg_wr}, 32'd0);

    // ALU single-cycle pulse
    issue(2'b00, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 3'b0);
    step();
    exif.ex_valid = 1'b0;
    check("alu reg_wr", {31'b0, reg_wr}, 32'd1);
    check("alu waddr", {27'b0, waddr}, 32'd5);
    check("alu wdata", wdata, 32'h0000_1234);
    check("alu fwd_valid", {31'b0, fwd_valid}, 32'd1);
    check("alu fwd_rd", {27'b0, fwd_rd}, 32'd5);
    step();
    check("alu pulse_end", {31'b0, reg_wr}, 32'd0);

    // Back-to-back PC+4 (wraps) then CSR
    issue(2'b10, 5'd1, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'b0);
    step();
    check("pc4 wdata", wdata, 32'h0000_0000);
    check("pc4 waddr", {27'b0, waddr}, 32'd1);
    check("pc4 reg_wr", {31'b0, reg_wr}, 32'd1);
    issue(2'b11, 5'd2, 1'b1, 32'h0, 32'h0, 32'hA5A5_0000, 3'b0);
    step();
    exif.ex_valid = 1'b0;
    check("csr wdata", wdata, 32'hA5A5_0000);
    check("csr reg_wr", {31'b0, reg_wr}, 32'd1);
    step();
    check("csr pulse_end", {31'b0, reg_wr}, 32'd0);

    // ALU op with rd=0 must not write
    issue(2'b00, 5'd0, 1'b1, 32'h0000_00AA, 32'h0, 32'h0, 3'b0);
    step();
    exif.ex_valid = 1'b0;
    check("alu rd0 reg_wr", {31'b0, reg_wr}, 32'd0);

    // rvalid in IDLE is ignored
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_rvalid = 1'b0;
    check("idle rvalid reg_wr", {31'b0, reg_wr}, 32'd0);
    check("idle rvalid stall", {31'b0, exif.stall}, 32'd0);

    // Load alignment
    do_load("lb", F3_LB, 32'h0000_1003, 32'h80FF_0000, 5'd3, 3, 1'b1, 32'hFFFF_FF80, 1'b0);
    step();
    check("lb pulse_end", {31'b0, reg_wr}, 32'd0);
    do_load("lbu", F3_LBU, 32'h0000_1003, 32'h80FF_0000, 5'd4, 3, 1'b1, 32'h0000_0080, 1'b0);
    do_load("lhu", F3_LHU, 32'h0000_1002, 32'h80FF_0000, 5'd6, 3, 1'b1, 32'h0000_80FF, 1'b0);
    do_load("lh", F3_LH, 32'h0000_1002, 32'h80FF_0000, 5'd7, 1, 1'b1, 32'hFFFF_80FF, 1'b0);
    do_load("lb0", F3_LB, 32'h0000_1000, 32'h1234_567F, 5'd8, 2, 1'b1, 32'h0000_007F, 1'b0);
    do_load("lw", F3_LW, 32'h0000_1000, 32'h1234_5678, 5'd9, 2, 1'b1, 32'h1234_5678, 1'b0);

    // Load to rd=0, then ALU op accepted the cycle right after rvalid
    do_load("ld_rd0", F3_LW, 32'h0000_2000, 32'hCAFE_F00D, 5'd0, 3, 1'b0, 32'h0, 1'b0);
    issue(2'b00, 5'd10, 1'b1, 32'h0000_0055, 32'h0, 32'h0, 3'b0);
    step();
    exif.ex_valid = 1'b0;
    check("after_ld reg_wr", {31'b0, reg_wr}, 32'd1);
    check("after_ld waddr", {27'b0, waddr}, 32'd10);
    check("after_ld wdata", wdata, 32'h0000_0055);

    // ex_valid held while stalled is not accepted until the stall drops
    issue(2'b01, 5'd11, 1'b1, 32'h0000_3001, 32'h0, 32'h0, F3_LBU);
    step();
    issue(2'b00, 5'd12, 1'b1, 32'h0000_0077, 32'h0, 32'h0, 3'b0);
    step();
    check("hold stall", {31'b0, exif.stall}, 32'd1);
    check("hold no_wr", {31'b0, reg_wr}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h0000_AB00;
    step();
    dmem_rvalid = 1'b0;
    check("hold ld wdata", wdata, 32'h0000_00AB);
    check("hold ld waddr", {27'b0, waddr}, 32'd11);
    step();
    exif.ex_valid = 1'b0;
    check("hold alu waddr", {27'b0, waddr}, 32'd12);
    check("hold alu wdata", wdata, 32'h0000_0077);
    step();
    check("hold end", {31'b0, reg_wr}, 32'd0);

    // Reset during WAIT_MEM discards the pending response
    issue(2'b01, 5'd13, 1'b1, 32'h0000_4000, 32'h0, 32'h0, F3_LW);
    step();
    exif.ex_valid = 1'b0;
    check("rstw stall", {31'b0, exif.stall}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw stall_off", {31'b0, exif.stall}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h1111_2222;
    step();
    dmem_rvalid = 1'b0;
    check("rstw no_wr", {31'b0, reg_wr}, 32'd0);
    check("rstw idle", {31'b0, exif.stall}, 32'd0);
    step();
    check("rstw no_wr2", {31'b0, reg_wr}, 32'd0);

    // Misaligned word load
`ifdef WB_MISALIGN_EN
    do_load("lw_mis", F3_LW, 32'h0000_5002, 32'hDEAD_BEEF, 5'd14, 2, 1'b0, 32'h0, 1'b1);
    step();
    check("lw_mis pulse_end", {31'b0, misalign_err}, 32'd0);
    do_load("lh_mis", F3_LH, 32'h0000_5001, 32'hDEAD_BEEF, 5'd15, 1, 1'b0, 32'h0, 1'b1);
`else
    do_load("lw_mis", F3_LW, 32'h0000_5002, 32'hDEAD_BEEF, 5'd14, 2, 1'b1, 32'hDEAD_BEEF, 1'b0);
    do_load("lh_mis", F3_LH, 32'h0000_5001, 32'hDEAD_BEEF, 5'd15, 1, 1'b1, 32'hFFFF_BEEF, 1'b0);
`endif
    step();
    check("final no_wr", {31'b0, reg_wr}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final stage of the 3-stage pipeline; sits directly upstream of the register file and drives its write port (reg_wr, waddr, wdata).
- Selects the writeback source: ALU, load data, PC+4 or CSR.
- Waits on the data-memory read response, with stall back-pressure to execute, then aligns and sign/zero-extends load data.
- Exposes the in-flight write for bypass.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
ex_valid  in  1  execute stage presents an instruction
ex_reg_wr  in  1  instruction writes rd
ex_rd  in  REG_AW  destination register
ex_wb_sel  in  2  00 ALU, 01 MEM, 10 PC+4, 11 CSR
ex_alu_result  in  XLEN  ALU result / load address
ex_pc  in  XLEN  instruction PC
ex_csr_rdata  in  XLEN  CSR read value
ex_funct3  in  3  load size/sign
dmem_rvalid  in  1  load data valid this cycle
dmem_rdata  in  XLEN  raw word from data memory
stall  out  1  execute must hold its instruction
reg_wr  out  1  register-file write enable
waddr  out  REG_AW  register-file write address
wdata  out  XLEN  register-file write data
fwd_valid  out  1  equals reg_wr; bypass qualifier
fwd_rd  out  REG_AW  equals waddr
fwd_data  out  XLEN  equals wdata

Behaviour:
- Reset: state IDLE; reg_wr=0, waddr=0, wdata=0, stall=0, misalign_err=0 (when compiled in); captured load context cleared.
- Clock/reset: one clock, clk; rst synchronous and active-high.
- Output timing: all write-port outputs registered on posedge and held the full cycle, so the register file's negedge capture sees stable values.
- FSM states:
  - IDLE: accept when ex_valid=1.
  - wb_sel != MEM -> next cycle reg_wr pulses for 1 cycle; wdata per source (PC+4 = ex_pc+4, mod 2^32); stay IDLE.
  - wb_sel = MEM -> latch rd, reg_wr, funct3, addr[1:0]; go to WAIT_MEM.
  - WAIT_MEM: stall=1 (decoded from state only, no combinational path from dmem_rvalid).
  - WAIT_MEM, dmem_rvalid=1 -> align data; next cycle write; state IDLE.
  - WAIT_MEM, dmem_rvalid=0 -> remain in WAIT_MEM indefinitely.
- Latency: non-load 1 cycle; load = response cycle + 1.
- Throughput: back-to-back non-loads accepted every cycle. Instruction after a load is accepted in the cycle after dmem_rvalid.
- Load alignment (offset = addr[1:0]):
  - LB 000: byte at offset*8, sign-extended.
  - LBU 100: same, zero-extended.
  - LH 001: half at addr[1]*16, sign-extended.
  - LHU 101: same, zero-extended.
  - LW 010 and undefined codes 011/110/111: full word.
- rd=0 or ex_reg_wr=0: reg_wr stays 0. The load still waits for its response; waddr/wdata are don't-care.
- ex_valid=0 in IDLE: no write; outputs reg_wr=0.
- dmem_rvalid in IDLE: ignored.
- rst during WAIT_MEM: return to IDLE; pending response discarded; no write issued.
- ex_valid while stall=1: not accepted; upstream holds.

Optional Feature:
- Macro WB_MISALIGN_EN.
- Defined: adds output port misalign_err (1 bit, registered).
  - Misaligned access = LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - On the write cycle, misalign_err pulses 1 and reg_wr is forced 0.
  - The response is still consumed, so FSM timing is unchanged.
- Undefined: port absent; misaligned addresses use forced alignment (low bits truncated as above) and write normally.

Decomposition:
- Shared package pipe_pkg:
  - wb_sel_e enum (WB_ALU, WB_MEM, WB_PC4, WB_CSR).
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - wb_state_e (IDLE, WAIT_MEM).
  - XLEN/REG_AW defaults.
- One sub-module, load_align: purely combinational; funct3, offset and raw word -> extended XLEN data.

Test Plan:
- ALU op rd=5, alu_result=0x0000_1234 -> 1 cycle later reg_wr=1, waddr=5, wdata=0x0000_1234, for exactly 1 cycle.
- PC+4 op pc=0xFFFF_FFFC, rd=1 -> wdata=0x0000_0000 (wrap); CSR op csr_rdata=0xA5A5_0000 -> wdata=0xA5A5_0000.
- LB addr=0x...3, rdata=0x80FF_0000, rvalid after 3 cycles:
  - stall=1 for exactly 3 cycles, then wdata=0xFFFF_FF80.
  - Same with LBU -> 0x0000_0080; LHU addr=...2 -> 0x0000_80FF.
- Load with rd=0 -> stall until rvalid, reg_wr never asserts; following ALU op accepted the cycle after rvalid.
- rst asserted in WAIT_MEM, then rvalid=1 next cycle -> no write; state IDLE; stall=0.
- WB_MISALIGN_EN: LW addr=0x...2 -> misalign_err=1 for one cycle, reg_wr=0. Without macro -> full word written.
